// File: rtl/lcd_pwr_pkg.sv
// Shared definitions for the LCD power sequencers.
// State encodings here are also decoded by the up-sequencer to detect its run state.
package lcd_pwr_pkg;

    // Default clock cycles per millisecond tick.
    localparam int unsigned CLK_PER_MS_DEF = 27000;

    // Width and maximum value of the millisecond counter.
    localparam int unsigned MS_CNT_W   = 9;
    localparam int unsigned MS_CNT_MAX = 511;

    // Power-down sequencer state encodings.
    localparam logic [2:0] PDN_ST_IDLE    = 3'd0;
    localparam logic [2:0] PDN_ST_HS_STOP = 3'd1;
    localparam logic [2:0] PDN_ST_3V0_DN  = 3'd2;
    localparam logic [2:0] PDN_ST_RST_DN  = 3'd3;
    localparam logic [2:0] PDN_ST_1V8_DN  = 3'd4;
    localparam logic [2:0] PDN_ST_OFF     = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE    = PDN_ST_IDLE,
        ST_HS_STOP = PDN_ST_HS_STOP,
        ST_3V0_DN  = PDN_ST_3V0_DN,
        ST_RST_DN  = PDN_ST_RST_DN,
        ST_1V8_DN  = PDN_ST_1V8_DN,
        ST_OFF     = PDN_ST_OFF
    } pdn_state_e;

    // Millisecond count at which an N ms dwell ends (on the last prescaler cycle).
    function automatic logic [MS_CNT_W-1:0] ms_last(input int unsigned n);
        return MS_CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/lcd_ms_timer.sv
// Millisecond timer: a prescaler counting 0..CLK_PER_MS-1 and a 9-bit ms counter
// that advances on each prescaler wrap. clr restarts both from zero on the next edge.
module lcd_ms_timer
    import lcd_pwr_pkg::*;
#(
    parameter int unsigned CLK_PER_MS = CLK_PER_MS_DEF
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                clr,
    output logic [MS_CNT_W-1:0] ms_cnt,
    output logic                tick_last
);

    localparam int unsigned   PW         = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_MS - 1);

    logic [PW-1:0]       presc_q, presc_d;
    logic [MS_CNT_W-1:0] ms_q, ms_d;

    // Next prescaler / ms count: clear wins, otherwise count with wrap into ms.
    always_comb begin
        presc_d = presc_q;
        ms_d    = ms_q;
        if (clr) begin
            presc_d = '0;
            ms_d    = '0;
        end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            ms_d    = ms_q + 1'b1;
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            presc_q <= '0;
            ms_q    <= '0;
        end else begin
            presc_q <= presc_d;
            ms_q    <= ms_d;
        end
    end

    assign ms_cnt    = ms_q;
    assign tick_last = (presc_q == PRESC_LAST);

endmodule

// File: rtl/lcd_pwr_dn_seq.sv
// LCD power-down sequencer. Stops DSI HS traffic, waits for the transmitter to
// idle, then drops the 3.0 V rail, asserts panel reset and drops the 1.8 V rail,
// each followed by a timed dwell. Outputs are active-high keep masks ANDed with
// the up-sequencer's outputs at the top level.
// Optional build macro: LCD_PDN_HS_TIMEOUT_EN enables the bounded tx_idle wait
// and the sticky hs_timeout flag; without it the tx_idle wait is unbounded.
//
// hs_stop / tx_idle handshake: hs_stop is a level request that rises on entry to
// ST_HS_STOP and then stays high; tx_idle is the transmitter's level response and
// is only looked at while in ST_HS_STOP. The first cycle tx_idle is seen high
// there completes the handshake.
module lcd_pwr_dn_seq
    import lcd_pwr_pkg::*;
#(
    parameter int unsigned CLK_PER_MS   = CLK_PER_MS_DEF,
    parameter int unsigned T_HS_STOP_MS = 20,
    parameter int unsigned T_3V0_OFF_MS = 5,
    parameter int unsigned T_RST_MS     = 10,
    parameter int unsigned T_1V8_OFF_MS = 5
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       pwr_dn_req,
    input  logic       seq_run,
    input  logic       tx_idle,
    output logic       hs_stop,
    output logic       v30_keep,
    output logic       rst_keep,
    output logic       v18_keep,
    output logic       pdn_done,
    output logic       hs_timeout,
    output logic [2:0] state_dbg
);

    // Elaboration checks on timing parameters.
    generate
        if (CLK_PER_MS < 2) begin : g_bad_clk_per_ms
            $error("lcd_pwr_dn_seq: CLK_PER_MS must be >= 2");
        end
        if (T_HS_STOP_MS < 1 || T_HS_STOP_MS > MS_CNT_MAX) begin : g_bad_t_hs_stop
            $error("lcd_pwr_dn_seq: T_HS_STOP_MS must be in 1..511");
        end
        if (T_3V0_OFF_MS < 1 || T_3V0_OFF_MS > MS_CNT_MAX) begin : g_bad_t_3v0
            $error("lcd_pwr_dn_seq: T_3V0_OFF_MS must be in 1..511");
        end
        if (T_RST_MS < 1 || T_RST_MS > MS_CNT_MAX) begin : g_bad_t_rst
            $error("lcd_pwr_dn_seq: T_RST_MS must be in 1..511");
        end
        if (T_1V8_OFF_MS < 1 || T_1V8_OFF_MS > MS_CNT_MAX) begin : g_bad_t_1v8
            $error("lcd_pwr_dn_seq: T_1V8_OFF_MS must be in 1..511");
        end
    endgenerate

    localparam logic [MS_CNT_W-1:0] HS_LAST  = ms_last(T_HS_STOP_MS);
    localparam logic [MS_CNT_W-1:0] V30_LAST = ms_last(T_3V0_OFF_MS);
    localparam logic [MS_CNT_W-1:0] RST_LAST = ms_last(T_RST_MS);
    localparam logic [MS_CNT_W-1:0] V18_LAST = ms_last(T_1V8_OFF_MS);

    pdn_state_e          state_q, state_d;
    logic                hs_stop_q, hs_stop_d;
    logic                v30_keep_q, v30_keep_d;
    logic                rst_keep_q, rst_keep_d;
    logic                v18_keep_q, v18_keep_d;
    logic                pdn_done_q, pdn_done_d;
    logic                hs_timeout_q, hs_timeout_d;
    logic                timer_clr;
    logic [MS_CNT_W-1:0] ms_cnt;
    logic                tick_last;
    logic [MS_CNT_W-1:0] dwell_last;
    logic                dwell_done;

    // The timer restarts on every state entry, so each dwell is measured from
    // the edge that entered the state.
    lcd_ms_timer #(
        .CLK_PER_MS (CLK_PER_MS)
    ) u_ms_timer (
        .clk       (clk),
        .resetn    (resetn),
        .clr       (timer_clr),
        .ms_cnt    (ms_cnt),
        .tick_last (tick_last)
    );

    // Select the ms count that ends the current state's dwell.
    always_comb begin
        dwell_last = '0;
        case (state_q)
            ST_HS_STOP: dwell_last = HS_LAST;
            ST_3V0_DN:  dwell_last = V30_LAST;
            ST_RST_DN:  dwell_last = RST_LAST;
            ST_1V8_DN:  dwell_last = V18_LAST;
            default:    dwell_last = '0;
        endcase
    end

    assign dwell_done = tick_last && (ms_cnt == dwell_last);

    // Next state, next registered outputs and timer clear.
    always_comb begin
        state_d      = state_q;
        hs_timeout_d = hs_timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (pwr_dn_req) begin
                    state_d = seq_run ? ST_HS_STOP : ST_3V0_DN;
                end
            end
            ST_HS_STOP: begin
                // tx_idle is tested first so it wins a tie with the timeout.
                if (tx_idle) begin
                    state_d = ST_3V0_DN;
                end
`ifdef LCD_PDN_HS_TIMEOUT_EN
                else if (dwell_done) begin
                    state_d      = ST_3V0_DN;
                    hs_timeout_d = 1'b1;
                end
`endif
            end
            ST_3V0_DN: begin
                if (dwell_done) state_d = ST_RST_DN;
            end
            ST_RST_DN: begin
                if (dwell_done) state_d = ST_1V8_DN;
            end
            ST_1V8_DN: begin
                if (dwell_done) state_d = ST_OFF;
            end
            ST_OFF: begin
                state_d = ST_OFF;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs follow the state being entered so they change on the same
        // edge as the state. The sequence is monotonic, so each mask is a
        // decode of how far along the sequence has got.
        hs_stop_d  = (state_d == ST_HS_STOP) || (hs_stop_q && (state_d != ST_IDLE));
        v30_keep_d = (state_d == ST_IDLE) || (state_d == ST_HS_STOP);
        rst_keep_d = v30_keep_d || (state_d == ST_3V0_DN);
        v18_keep_d = rst_keep_d || (state_d == ST_RST_DN);
        pdn_done_d = (state_d == ST_OFF);

`ifdef LCD_PDN_HS_TIMEOUT_EN
        if (state_d == ST_IDLE) hs_timeout_d = 1'b0;
`else
        hs_timeout_d = 1'b0;
`endif

        timer_clr = (state_d != state_q);
    end

    // State and output registers; reset returns everything to the idle values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            hs_stop_q    <= 1'b0;
            v30_keep_q   <= 1'b1;
            rst_keep_q   <= 1'b1;
            v18_keep_q   <= 1'b1;
            pdn_done_q   <= 1'b0;
            hs_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hs_stop_q    <= hs_stop_d;
            v30_keep_q   <= v30_keep_d;
            rst_keep_q   <= rst_keep_d;
            v18_keep_q   <= v18_keep_d;
            pdn_done_q   <= pdn_done_d;
            hs_timeout_q <= hs_timeout_d;
        end
    end

    assign hs_stop    = hs_stop_q;
    assign v30_keep   = v30_keep_q;
    assign rst_keep   = rst_keep_q;
    assign v18_keep   = v18_keep_q;
    assign pdn_done   = pdn_done_q;
    assign hs_timeout = hs_timeout_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_lcd_pwr_dn_seq.sv
// Testbench for lcd_pwr_dn_seq with CLK_PER_MS=4 and default dwell times.
// Expected output timelines are computed from event times in cycles: the
// request edge, the edge at which tx_idle is sampled, and the dwell lengths.
module tb_lcd_pwr_dn_seq;
    import lcd_pwr_pkg::*;

    localparam int C      = 4;
    localparam int T_HS   = 20;
    localparam int T_3V0  = 5;
    localparam int T_RST  = 10;
    localparam int T_1V8  = 5;
`ifdef LCD_PDN_HS_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    // Clock and reset
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       pwr_dn_req = 1'b0;
    logic       seq_run = 1'b0;
    logic       tx_idle = 1'b0;
    logic       hs_stop, v30_keep, rst_keep, v18_keep, pdn_done, hs_timeout;
    logic [2:0] state_dbg;

    always #5 clk = ~clk;

    lcd_pwr_dn_seq #(
        .CLK_PER_MS   (C),
        .T_HS_STOP_MS (T_HS),
        .T_3V0_OFF_MS (T_3V0),
        .T_RST_MS     (T_RST),
        .T_1V8_OFF_MS (T_1V8)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .pwr_dn_req (pwr_dn_req),
        .seq_run    (seq_run),
        .tx_idle    (tx_idle),
        .hs_stop    (hs_stop),
        .v30_keep   (v30_keep),
        .rst_keep   (rst_keep),
        .v18_keep   (v18_keep),
        .pdn_done   (pdn_done),
        .hs_timeout (hs_timeout),
        .state_dbg  (state_dbg)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input string name, input int k,
                       input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s.%s step %0d: observed %b expected %b", tag, name, k, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [2:0] exp);
        n_checks++;
        assert (state_dbg === exp) else begin
            n_errors++;
            $error("FAIL %s.state: observed %0d expected %0d", tag, state_dbg, exp);
        end
    endtask

    task automatic check_all(input string tag, input int k,
                             input logic e_hs, input logic e_v30, input logic e_rst,
                             input logic e_v18, input logic e_done, input logic e_to);
        chk(tag, "hs_stop",    k, hs_stop,    e_hs);
        chk(tag, "v30_keep",   k, v30_keep,   e_v30);
        chk(tag, "rst_keep",   k, rst_keep,   e_rst);
        chk(tag, "v18_keep",   k, v18_keep,   e_v18);
        chk(tag, "pdn_done",   k, pdn_done,   e_done);
        chk(tag, "hs_timeout", k, hs_timeout, e_to);
    endtask

    // Assert resetn mid-cycle, check the asynchronous return to reset values,
    // then release on a falling edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        resetn     = 1'b0;
        pwr_dn_req = 1'b0;
        #1;
        check_all(tag, -1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk_state(tag, ST_IDLE);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    // One shutdown: `pre` idle cycles, then a request with seq_run=s; tx_idle is
    // first sampled high d edges after the request edge. Runs to stop_at (or to
    // 10 cycles past completion when stop_at < 0), checking every cycle.
    task automatic run_seq(input string tag, input bit s, input int d,
                           input int stop_at, input int pre);
        int e3, er, e18, eoff, last;
        bit to;

        // Reference timeline, in edges after the request edge (edge 0).
        if (!s) begin
            e3 = 0;
            to = 1'b0;
        end else if (TO_EN && d > T_HS * C) begin
            e3 = T_HS * C;
            to = 1'b1;
        end else begin
            e3 = d;
            to = 1'b0;
        end
        er   = e3 + T_3V0 * C;
        e18  = er + T_RST * C;
        eoff = e18 + T_1V8 * C;
        last = (stop_at >= 0) ? stop_at : eoff + 10;

        for (int i = 0; i < pre; i++) begin
            @(negedge clk);
            check_all({tag, ".idle"}, i, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            pwr_dn_req = 1'b0;
            seq_run    = 1'($urandom_range(0, 1));
            tx_idle    = 1'($urandom_range(0, 1));
        end

        @(negedge clk);
        pwr_dn_req = 1'b1;
        seq_run    = s;
        tx_idle    = 1'b0;

        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            check_all(tag, k, s, k < e3, k < er, k < e18, k >= eoff, to && (k >= e3));
            // After acceptance the request level must not matter.
            pwr_dn_req = 1'($urandom_range(0, 1));
            if (k + 1 < d)       tx_idle = 1'b0;
            else if (k + 1 == d) tx_idle = 1'b1;
            else                 tx_idle = 1'($urandom_range(0, 1));
        end

        if (stop_at < 0) chk_state({tag, ".end"}, ST_OFF);
    endtask

    initial begin
        bit rs;
        int rd, rp;

        do_reset("reset0");

        // Normal path: tx_idle 7 cycles after the request.
        run_seq("normal", 1'b1, 7, -1, 5);

        // Up-sequencer not running: skip the HS stop phase.
        do_reset("reset1");
        run_seq("no_run", 1'b0, 1, -1, 3);

        // tx_idle never arrives within 1000 cycles: timeout, or hold without it.
        do_reset("reset2");
        run_seq("timeout", 1'b1, 1000, -1, 2);

        // tx_idle sampled on the same edge the timeout fires.
        do_reset("reset3");
        run_seq("tie", 1'b1, T_HS * C, -1, 2);

        // Reset during ST_RST_DN (edges 32..71 here), then a full repeat.
        do_reset("reset4");
        run_seq("mid", 1'b1, 12, 50, 2);
        do_reset("mid_rst");
        run_seq("repeat", 1'b1, 12, -1, 2);

        // Randomized shutdowns.
        for (int n = 0; n < 6; n++) begin
            rs = 1'($urandom_range(0, 1));
            rd = int'($urandom_range(1, 90));
            rp = int'($urandom_range(0, 4));
            do_reset("reset_rnd");
            run_seq("rnd", rs, rd, -1, rp);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
